// File: rtl/pipe_stage_buffer.sv
// Parametrised pipeline stage register with valid/ready handshake, optional
// two-entry skid buffer, flush with bubble injection and saturating perf counters.
module pipe_stage_buffer #(
    parameter int unsigned       DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(64'h0000_0000_0000_0033),
    parameter bit                SKID   = 1'b1,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;
    logic              push, pop;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    // With the skid entry present, in_ready comes straight from a flop so the
    // upstream stage never sees a combinational path from out_ready.
    assign in_ready = SKID ? in_ready_q : ((state_q == EMPTY) | out_ready);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push && SKID) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    // NOTE: payload registers are reset as well, because an empty stage must
    // present BUBBLE on out_data straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= BUBBLE;
            skid_q     <= BUBBLE;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Drives a skid build (4-bit counters) and a no-skid build with shared stimulus
// and checks both against a small FIFO-level reference model.
module tb_pipe_stage_buffer;

    localparam logic [63:0] BUBBLE = 64'h0000_0000_0000_0033;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        flush;

    logic        rdy_s, vld_s, rdy_n, vld_n;
    logic [63:0] dat_s, dat_n;
    logic [1:0]  occ_s, occ_n;
    logic [3:0]  stl_s, fl_s;
    logic [15:0] stl_n, fl_n;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: index 0 = skid build, 1 = no-skid build.
    int          m_n[2];
    logic [63:0] m_q[2][2];
    int          m_stall[2];
    int          m_flush[2];
    int          cap[2] = '{15, 65535};

    always #5 clk = ~clk;

    pipe_stage_buffer #(.DATA_W(64), .BUBBLE(BUBBLE), .SKID(1'b1), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
        .out_valid(vld_s), .out_ready(out_ready), .out_data(dat_s),
        .flush(flush), .occupancy(occ_s), .stall_cnt(stl_s), .flush_cnt(fl_s)
    );

    pipe_stage_buffer #(.DATA_W(64), .BUBBLE(BUBBLE), .SKID(1'b0), .CNT_W(16)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy_n), .in_data(in_data),
        .out_valid(vld_n), .out_ready(out_ready), .out_data(dat_n),
        .flush(flush), .occupancy(occ_n), .stall_cnt(stl_n), .flush_cnt(fl_n)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare(input int d, input logic rdy, input logic vld,
                           input logic [63:0] dat, input logic [1:0] occ,
                           input int stl, input int fl);
        logic exp_rdy;
        string tag;
        tag = (d == 0) ? "skid" : "noskid";
        exp_rdy = (d == 0) ? (m_n[d] != 2) : (m_n[d] == 0 || out_ready);
        check({tag, ".in_ready"},  64'(rdy), 64'(exp_rdy));
        check({tag, ".out_valid"}, 64'(vld), 64'(m_n[d] > 0));
        check({tag, ".out_data"},  dat, (m_n[d] > 0) ? m_q[d][0] : BUBBLE);
        check({tag, ".occupancy"}, 64'(occ), 64'(m_n[d]));
        check({tag, ".stall_cnt"}, 64'(stl), 64'(m_stall[d]));
        check({tag, ".flush_cnt"}, 64'(fl), 64'(m_flush[d]));
    endtask

    task automatic advance(input int d);
        logic acc, take;
        acc  = (d == 0) ? (m_n[d] != 2) : (m_n[d] == 0 || out_ready);
        acc  = acc && in_valid;
        take = (m_n[d] > 0) && out_ready;
        if (m_n[d] > 0 && !out_ready && m_stall[d] < cap[d]) m_stall[d]++;
        if (flush && m_flush[d] < cap[d]) m_flush[d]++;
        if (flush) begin
            m_n[d] = 0;
        end else begin
            if (take) begin
                m_q[d][0] = m_q[d][1];
                m_n[d]--;
            end
            if (acc) begin
                m_q[d][m_n[d]] = in_data;
                m_n[d]++;
            end
        end
    endtask

    // Monitor: compares DUT outputs with the model mid-cycle, then advances it.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_n[d] = 0;
                m_stall[d] = 0;
                m_flush[d] = 0;
            end
        end
        compare(0, rdy_s, vld_s, dat_s, occ_s, int'(stl_s), int'(fl_s));
        compare(1, rdy_n, vld_n, dat_n, occ_n, int'(stl_n), int'(fl_n));
        if (rst_n) begin
            advance(0);
            advance(1);
        end
    end

    task automatic drive(input logic v, input logic [63:0] dt, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = dt;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        rst_n = 1'b1;

        // Streaming at full throughput.
        for (int i = 1; i <= 4; i++) drive(1, 64'(i), 1, 0);
        repeat (3) drive(0, 0, 1, 0);

        // Fill with back-pressure, then drain.
        drive(1, 64'hA, 0, 0);
        drive(1, 64'hB, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        repeat (3) drive(0, 0, 1, 0);

        // Flush a full stage while a push is offered.
        drive(1, 64'h11, 0, 0);
        drive(1, 64'h12, 0, 0);
        drive(1, 64'hC, 0, 1);
        repeat (2) drive(0, 0, 1, 0);

        // Long stall to saturate the 4-bit counter.
        drive(1, 64'h21, 0, 0);
        repeat (20) drive(0, 0, 0, 0);
        check("skid.stall_sat", 64'(stl_s), 64'd15);
        repeat (2) drive(0, 0, 1, 0);

        // Randomised traffic with occasional flushes and stall bursts.
        for (int i = 0; i < 800; i++) begin
            drive(($urandom % 4) != 0, {$urandom, $urandom},
                  (i % 100 < 80) ? (($urandom % 3) != 0) : 1'b0,
                  ($urandom % 25) == 0);
        end

        // Asynchronous reset while the skid build is full.
        repeat (3) drive(0, 0, 1, 0);
        drive(1, 64'h31, 0, 0);
        drive(1, 64'h32, 0, 0);
        check("skid.pre_reset_occ", 64'(occ_s), 64'd2);
        rst_n = 1'b0;
        #1;
        check("async.occupancy", 64'(occ_s), 64'd0);
        check("async.out_valid", 64'(vld_s), 64'd0);
        check("async.out_data",  dat_s, BUBBLE);
        check("async.in_ready",  64'(rdy_s), 64'd1);
        check("async.stall_cnt", 64'(stl_s), 64'd0);
        check("async.flush_cnt", 64'(fl_s), 64'd0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
        drive(1, 64'h41, 1, 0);
        repeat (3) drive(0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
